// File: rtl/ika87ad_busmem.sv
// External-bus memory for the IKA87AD core: decoded ROM/RAM/IO regions,
// programmable read latency, ROM write protection and a ROM preload port.
module ika87ad_busmem #(
    parameter int          ROM_AW   = 12,
    parameter logic [15:0] ROM_BASE = 16'h0000,
    parameter int          RAM_AW   = 8,
    parameter logic [15:0] RAM_BASE = 16'hFF00,
    parameter logic [15:0] IO_ADDR  = 16'h1401,
    parameter logic [7:0]  IO_INIT  = 8'hEE,
    parameter logic [7:0]  OPEN_BUS = 8'hFF,
    parameter int          RD_LAT   = 1
) (
    input  logic              i_EMUCLK,
    input  logic              i_RESET_n,
    input  logic [15:0]       i_A,
    input  logic              i_RD_n,
    input  logic              i_WR_n,
    input  logic [7:0]        i_DI,
    output logic [7:0]        o_DO,
    output logic              o_DO_OE,
    input  logic              i_LD_VALID,
    input  logic [ROM_AW-1:0] i_LD_ADDR,
    input  logic [7:0]        i_LD_DATA,
    output logic              o_LD_READY,
    output logic [7:0]        o_IO_REG,
    output logic              o_WP_ERR
);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_WAIT  = 2'd1;
    localparam logic [1:0] R_DRIVE = 2'd2;
    localparam logic [1:0] LAT_M1  = 2'(RD_LAT - 1);
    localparam int         MW      = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wreq_t;

    function automatic logic hit_io(input logic [15:0] a);
        return a == IO_ADDR;
    endfunction

    function automatic logic hit_ram(input logic [15:0] a);
        return a[15:RAM_AW] == RAM_BASE[15:RAM_AW];
    endfunction

    function automatic logic hit_rom(input logic [15:0] a);
        return a[15:ROM_AW] == ROM_BASE[15:ROM_AW];
    endfunction

    logic [7:0]  rom [0:(1<<ROM_AW)-1];
    logic [7:0]  ram [0:(1<<RAM_AW)-1];
    logic [7:0]  rom_q, ram_q, rd_data;
    logic [1:0]  state, cnt;
    logic        rd_q, wr_q;
    logic [15:0] a_q;
    wreq_t       wreq;
    logic        wr_commit, rd_start;
    logic [MW-1:0] rd_off;

    assign wr_commit  = ~wr_q & i_WR_n;
    assign rd_start   = (state == R_IDLE) & rd_q & ~i_RD_n & i_WR_n;
    // Array read address follows the bus while idle so the start edge already
    // fetches; afterwards it tracks the latched address.
    assign rd_off     = (state == R_IDLE) ? i_A[MW-1:0] : a_q[MW-1:0];
    assign o_LD_READY = i_RESET_n & (state == R_IDLE) & i_RD_n & i_WR_n & ~wr_commit;

    always_comb begin
        rd_data = OPEN_BUS;
        if (hit_io(a_q))       rd_data = o_IO_REG;
        else if (hit_ram(a_q)) rd_data = ram_q;
        else if (hit_rom(a_q)) rd_data = rom_q;
    end

    // Arrays carry no reset so they map onto block RAM and survive i_RESET_n.
    always_ff @(posedge i_EMUCLK) begin
        rom_q <= rom[rd_off[ROM_AW-1:0]];
        ram_q <= ram[rd_off[RAM_AW-1:0]];
        if (wr_commit && !hit_io(wreq.a) && hit_ram(wreq.a))
            ram[wreq.a[RAM_AW-1:0]] <= wreq.d;
        if (i_LD_VALID && o_LD_READY)
            rom[i_LD_ADDR] <= i_LD_DATA;
    end

    always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            state    <= R_IDLE;
            cnt      <= 2'd0;
            a_q      <= 16'h0000;
            wreq     <= '0;
            o_DO     <= 8'h00;
            o_DO_OE  <= 1'b0;
            o_IO_REG <= IO_INIT;
            o_WP_ERR <= 1'b0;
        end else begin
            rd_q <= i_RD_n;
            wr_q <= i_WR_n;
            if (!i_WR_n)
                wreq <= '{a: i_A, d: i_DI};
            if (wr_commit) begin
                if (hit_io(wreq.a))
                    o_IO_REG <= wreq.d;
                else if (!hit_ram(wreq.a) && hit_rom(wreq.a))
                    o_WP_ERR <= 1'b1;
            end
            // A low write strobe wins over any read in progress.
            case (state)
                R_IDLE: begin
                    if (rd_start) begin
                        a_q   <= i_A;
                        cnt   <= 2'd0;
                        state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (i_RD_n || !i_WR_n) begin
                        state <= R_IDLE;
                    end else if (cnt == LAT_M1) begin
                        o_DO    <= rd_data;
                        o_DO_OE <= 1'b1;
                        state   <= R_DRIVE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                R_DRIVE: begin
                    if (i_RD_n || !i_WR_n) begin
                        o_DO_OE <= 1'b0;
                        state   <= R_IDLE;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ika87ad_busmem.sv
// Directed bench for ika87ad_busmem: two instances (RD_LAT=2 and RD_LAT=3)
// share one bus so latency differences show up side by side.
module tb_ika87ad_busmem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] A;
    logic        RD_n, WR_n;
    logic [7:0]  DI;
    logic        LD_VALID;
    logic [11:0] LD_ADDR;
    logic [7:0]  LD_DATA;

    logic [7:0]  do2, do3, io2, io3;
    logic        oe2, oe3, ldr2, ldr3, wp2, wp3;

    int n_cmp = 0;
    int n_err = 0;

    logic       oe2_h [1:6];
    logic       oe3_h [1:6];
    logic [7:0] do2_h [1:6];
    logic [7:0] do3_h [1:6];
    logic       rdy_c;

    always #5 clk = ~clk;

    ika87ad_busmem #(.RD_LAT(2)) u_dut2 (
        .i_EMUCLK(clk), .i_RESET_n(rst_n), .i_A(A), .i_RD_n(RD_n), .i_WR_n(WR_n),
        .i_DI(DI), .o_DO(do2), .o_DO_OE(oe2), .i_LD_VALID(LD_VALID),
        .i_LD_ADDR(LD_ADDR), .i_LD_DATA(LD_DATA), .o_LD_READY(ldr2),
        .o_IO_REG(io2), .o_WP_ERR(wp2)
    );

    ika87ad_busmem #(.RD_LAT(3)) u_dut3 (
        .i_EMUCLK(clk), .i_RESET_n(rst_n), .i_A(A), .i_RD_n(RD_n), .i_WR_n(WR_n),
        .i_DI(DI), .o_DO(do3), .o_DO_OE(oe3), .i_LD_VALID(LD_VALID),
        .i_LD_ADDR(LD_ADDR), .i_LD_DATA(LD_DATA), .o_LD_READY(ldr3),
        .o_IO_REG(io3), .o_WP_ERR(wp3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold RD_n low for five edges (index 1 = detecting edge), then release.
    task automatic do_read(input logic [15:0] a);
        A = a;
        RD_n = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            oe2_h[e] = oe2; do2_h[e] = do2; oe3_h[e] = oe3; do3_h[e] = do3;
        end
        RD_n = 1'b1;
        tick();
        oe2_h[6] = oe2; do2_h[6] = do2; oe3_h[6] = oe3; do3_h[6] = do3;
        tick();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        A = a; DI = d; WR_n = 1'b0;
        tick();
        WR_n = 1'b1;
        #1;
        rdy_c = ldr2;
        tick();
    endtask

    task automatic do_load(input logic [11:0] a, input logic [7:0] d, output logic acc);
        acc = 1'b0;
        LD_ADDR = a; LD_DATA = d; LD_VALID = 1'b1;
        for (int i = 0; i < 8 && !acc; i++) begin
            if (ldr2 && ldr3) acc = 1'b1;
            tick();
        end
        LD_VALID = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; A = 16'h0000; RD_n = 1'b1; WR_n = 1'b1; DI = 8'h00;
        LD_VALID = 1'b0; LD_ADDR = 12'h000; LD_DATA = 8'h00;
        #12;
        n_cmp++; if (do2 !== 8'h00) begin n_err++; $display("FAIL rst_do got %h want 00", do2); end
        n_cmp++; if (oe2 !== 1'b0) begin n_err++; $display("FAIL rst_oe got %b want 0", oe2); end
        n_cmp++; if (io2 !== 8'hEE) begin n_err++; $display("FAIL rst_io got %h want ee", io2); end
        n_cmp++; if (wp2 !== 1'b0) begin n_err++; $display("FAIL rst_wp got %b want 0", wp2); end
        n_cmp++; if (ldr2 !== 1'b0) begin n_err++; $display("FAIL rst_ldr got %b want 0", ldr2); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (ldr2 !== 1'b1) begin n_err++; $display("FAIL post_rst_ldr got %b want 1", ldr2); end
    endtask

    task automatic test_io_open();
        do_read(16'h1401);
        n_cmp++; if (oe2_h[3] !== 1'b1 || do2_h[3] !== 8'hEE) begin n_err++; $display("FAIL io_rd2 got %b/%h want 1/ee", oe2_h[3], do2_h[3]); end
        n_cmp++; if (do3_h[4] !== 8'hEE) begin n_err++; $display("FAIL io_rd3 got %h want ee", do3_h[4]); end
        do_write(16'h1401, 8'h5A);
        n_cmp++; if (io2 !== 8'h5A || io3 !== 8'h5A) begin n_err++; $display("FAIL io_wr got %h/%h want 5a", io2, io3); end
        n_cmp++; if (rdy_c !== 1'b0) begin n_err++; $display("FAIL ldr_commit got %b want 0", rdy_c); end
        do_read(16'h8000);
        n_cmp++; if (do2_h[3] !== 8'hFF || do3_h[4] !== 8'hFF) begin n_err++; $display("FAIL open_bus got %h/%h want ff", do2_h[3], do3_h[4]); end
    endtask

    task automatic test_preload_read();
        logic acc;
        do_load(12'h010, 8'hA5, acc);
        n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL load_accept got %b want 1", acc); end
        do_read(16'h0010);
        n_cmp++; if (oe2_h[2] !== 1'b0) begin n_err++; $display("FAIL lat2_early got %b want 0", oe2_h[2]); end
        n_cmp++; if (oe2_h[3] !== 1'b1 || do2_h[3] !== 8'hA5) begin n_err++; $display("FAIL lat2_data got %b/%h want 1/a5", oe2_h[3], do2_h[3]); end
        n_cmp++; if (oe3_h[3] !== 1'b0) begin n_err++; $display("FAIL lat3_early got %b want 0", oe3_h[3]); end
        n_cmp++; if (oe3_h[4] !== 1'b1 || do3_h[4] !== 8'hA5) begin n_err++; $display("FAIL lat3_data got %b/%h want 1/a5", oe3_h[4], do3_h[4]); end
        n_cmp++; if (oe2_h[6] !== 1'b0 || do2_h[6] !== 8'hA5) begin n_err++; $display("FAIL rd_release got %b/%h want 0/a5", oe2_h[6], do2_h[6]); end
    endtask

    task automatic test_ram();
        do_write(16'hFF20, 8'h3C);
        do_read(16'hFF20);
        n_cmp++; if (do2_h[3] !== 8'h3C || do3_h[4] !== 8'h3C) begin n_err++; $display("FAIL ram_rd got %h/%h want 3c", do2_h[3], do3_h[4]); end
        n_cmp++; if (wp2 !== 1'b0) begin n_err++; $display("FAIL ram_wp got %b want 0", wp2); end
    endtask

    task automatic test_wp();
        do_write(16'h0010, 8'h00);
        n_cmp++; if (wp2 !== 1'b1) begin n_err++; $display("FAIL wp_set got %b want 1", wp2); end
        do_read(16'h0010);
        n_cmp++; if (do2_h[3] !== 8'hA5) begin n_err++; $display("FAIL wp_rom got %h want a5", do2_h[3]); end
        repeat (3) tick();
        n_cmp++; if (wp2 !== 1'b1 || wp3 !== 1'b1) begin n_err++; $display("FAIL wp_sticky got %b/%b want 1", wp2, wp3); end
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        A = 16'hFF20; RD_n = 1'b0;
        tick();
        RD_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | oe2 | oe3;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_oe got %b want 0", seen); end
        n_cmp++; if (do2 !== 8'hA5 || do3 !== 8'hA5) begin n_err++; $display("FAIL abort_do got %h/%h want a5", do2, do3); end
    endtask

    task automatic test_collision();
        logic seen = 1'b0;
        A = 16'hFF21; DI = 8'h77; RD_n = 1'b0; WR_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | oe2 | oe3;
        end
        RD_n = 1'b1; WR_n = 1'b1;
        tick();
        seen = seen | oe2 | oe3;
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL coll_oe got %b want 0", seen); end
        tick();
        do_read(16'hFF21);
        n_cmp++; if (do2_h[3] !== 8'h77 || do3_h[4] !== 8'h77) begin n_err++; $display("FAIL coll_wr got %h/%h want 77", do2_h[3], do3_h[4]); end
        A = 16'hFF20; RD_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (oe2 !== 1'b1) begin n_err++; $display("FAIL drive_pre got %b want 1", oe2); end
        DI = 8'h3C; WR_n = 1'b0;
        tick();
        n_cmp++; if (oe2 !== 1'b0 || oe3 !== 1'b0) begin n_err++; $display("FAIL drive_abort got %b/%b want 0", oe2, oe3); end
        WR_n = 1'b1; RD_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_ld_hold();
        logic seen = 1'b0;
        LD_ADDR = 12'h020; LD_DATA = 8'h99; LD_VALID = 1'b1;
        A = 16'hFF20; RD_n = 1'b0;
        #1;
        seen = ldr2 | ldr3;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | ldr2 | ldr3;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL ld_busy got %b want 0", seen); end
        RD_n = 1'b1;
        tick();
        n_cmp++; if (ldr2 !== 1'b1) begin n_err++; $display("FAIL ld_free got %b want 1", ldr2); end
        tick();
        LD_VALID = 1'b0;
        do_read(16'h0020);
        n_cmp++; if (do2_h[3] !== 8'h99) begin n_err++; $display("FAIL ld_data got %h want 99", do2_h[3]); end
    endtask

    task automatic test_reset_mid_read();
        A = 16'hFF20; RD_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (oe2 !== 1'b1 || do2 !== 8'h3C) begin n_err++; $display("FAIL mid_pre got %b/%h want 1/3c", oe2, do2); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (oe2 !== 1'b0 || do2 !== 8'h00) begin n_err++; $display("FAIL mid_rst got %b/%h want 0/00", oe2, do2); end
        n_cmp++; if (io2 !== 8'hEE || wp2 !== 1'b0) begin n_err++; $display("FAIL mid_rst_regs got %h/%b want ee/0", io2, wp2); end
        RD_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        do_read(16'hFF20);
        n_cmp++; if (do2_h[3] !== 8'h3C || do3_h[4] !== 8'h3C) begin n_err++; $display("FAIL ram_persist got %h/%h want 3c", do2_h[3], do3_h[4]); end
    endtask

    initial begin
        test_reset();
        test_io_open();
        test_preload_read();
        test_ram();
        test_wp();
        test_abort();
        test_collision();
        test_ld_hold();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
